// File: rtl/ltl_mon_pkg.sv
// Shared types and constants for the monitor symbol interface.
// Symbols use only the 0..127 alphabet; bit 7 is reserved and always 0.
package ltl_mon_pkg;

    localparam int SYM_W = 8;

    typedef logic [SYM_W-1:0] sym_t;

    localparam sym_t ALPHA_MAX = 8'd127;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_PRIME,
        ENC_STREAM,
        ENC_DRAIN
    } enc_state_e;

endpackage

// File: rtl/ltl_sym_fifo.sv
// Synchronous symbol FIFO. Push and pop in the same cycle are both honoured
// even when full, since the pop frees the slot the push is written into.
module ltl_sym_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ltl_sym_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ltl_symbol_encoder.sv
// Transmit side of the monitor symbol interface: encodes proposition vectors into
// symbols, buffers them, and sequences mon_reset ahead of the first symbol.
module ltl_symbol_encoder
    import ltl_mon_pkg::*;
#(
    parameter int PROP_W       = 7,
    parameter int FIFO_DEPTH   = 8,
    parameter int PRIME_CYCLES = 2,
    parameter int CNT_W        = 16,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              prop_valid_i,
    input  logic [PROP_W-1:0] prop_bits_i,
    input  logic              sym_ready_i,
    output logic [SYM_W-1:0]  symbols_o,
    output logic              run_o,
    output logic              mon_reset_o,
    output logic              busy_o,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic [CNT_W-1:0]  overflow_cnt_o
);

    if (PROP_W < 1 || PROP_W > 7) begin : g_bad_prop_w
        $error("ltl_symbol_encoder: PROP_W must be in 1..7");
    end
    if (PRIME_CYCLES < 1) begin : g_bad_prime
        $error("ltl_symbol_encoder: PRIME_CYCLES must be >= 1");
    end

    localparam int PCW = $clog2(PRIME_CYCLES + 1);

    enc_state_e       state_q, state_d;
    logic [PCW-1:0]   prime_cnt_q, prime_cnt_d;
    sym_t             sym_q;
    logic             run_q;
    logic [CNT_W-1:0] ovf_q;

    logic             push_req, pop_en, drop;
    logic             fifo_full, fifo_empty;
    sym_t             push_sym, head_sym;

    assign push_sym = sym_t'(prop_bits_i) & ALPHA_MAX;
    assign push_req = prop_valid_i && (state_q == ENC_PRIME || state_q == ENC_STREAM);
    assign pop_en   = (state_q == ENC_STREAM || state_q == ENC_DRAIN) && !fifo_empty && sym_ready_i;
    assign drop     = push_req && fifo_full && !pop_en;

    ltl_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SYM_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .wdata_i (push_sym),
        .pop_i   (pop_en),
        .rdata_o (head_sym),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        unique case (state_q)
            ENC_IDLE: begin
                if (start_i) begin
                    state_d     = ENC_PRIME;
                    prime_cnt_d = PCW'(PRIME_CYCLES - 1);
                end
            end
            ENC_PRIME: begin
                if (prime_cnt_q == '0) state_d = ENC_STREAM;
                else                   prime_cnt_d = prime_cnt_q - PCW'(1);
            end
            ENC_STREAM: begin
                if (stop_i) state_d = ENC_DRAIN;
            end
            // Wait for the last popped symbol to leave the output register too.
            ENC_DRAIN: begin
                if (fifo_empty && !run_q) state_d = ENC_IDLE;
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ENC_IDLE;
            prime_cnt_q <= '0;
            sym_q       <= '0;
            run_q       <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            run_q       <= pop_en;
            if (pop_en) sym_q <= head_sym;
            if (drop && ovf_q != '1) ovf_q <= ovf_q + CNT_W'(1);
        end
    end

    assign symbols_o      = sym_q;
    assign run_o          = run_q;
    assign mon_reset_o    = (state_q == ENC_PRIME);
    assign busy_o         = (state_q != ENC_IDLE);
    assign overflow_cnt_o = ovf_q;

endmodule
